// File: rtl/board_io_pkg.sv
// ============================================================================
// board_io_pkg : shared constants, helpers and types for board_io_ctrl
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package board_io_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 20000;
    localparam int PWM_W_DEFAULT           = 8;

    // Debounce counter width; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

    typedef struct packed {
        logic meta;
        logic sync;
        logic stable;
    } db_state_t;

endpackage

`default_nettype wire

// File: rtl/board_io_debounce.sv
// ============================================================================
// board_io_debounce : one input channel - 2-flop sync, debounce, edge pulses
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module board_io_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    db_state_t     st;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (st.sync != st.stable) && (cnt == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st     <= '0;
            cnt    <= '0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            st.meta <= raw_i;
            st.sync <= st.meta;
            // Any return to the stable value restarts the count.
            if (st.sync == st.stable) begin
                cnt <= '0;
            end else if (accept) begin
                cnt       <= '0;
                st.stable <= ~st.stable;
            end else begin
                cnt <= cnt + CW'(1);
            end
            rise_o <= accept & ~st.stable;
            fall_o <= accept &  st.stable;
        end
    end

    assign level_o = st.stable;

endmodule

`default_nettype wire

// File: rtl/board_io_ctrl.sv
// ============================================================================
// board_io_ctrl : button/switch debounce, LED PWM, optional sticky button events
// Optional feature macro: BOARD_IO_EVENT_IRQ_EN
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int N_SW            = 2,
    parameter int N_LED           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int PWM_W           = PWM_W_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_BTN-1:0]       btn_i,
    input  logic [N_SW-1:0]        sw_i,
    output logic [N_BTN-1:0]       btn_o,
    output logic [N_BTN-1:0]       btn_rise_o,
    output logic [N_BTN-1:0]       btn_fall_o,
    output logic [N_SW-1:0]        sw_o,
    input  logic [N_LED*PWM_W-1:0] led_duty_i,
    output logic [N_LED-1:0]       led_o,
    input  logic [N_BTN-1:0]       evt_clr_i,
    output logic [N_BTN-1:0]       evt_o,
    output logic                   irq_o
);

    localparam logic [PWM_W-1:0] CNT_TOP = '1;

    logic [N_SW-1:0] sw_rise_unused;
    logic [N_SW-1:0] sw_fall_unused;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        board_io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .raw_i   (btn_i[i]),
            .level_o (btn_o[i]),
            .rise_o  (btn_rise_o[i]),
            .fall_o  (btn_fall_o[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        board_io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .raw_i   (sw_i[i]),
            .level_o (sw_o[i]),
            .rise_o  (sw_rise_unused[i]),
            .fall_o  (sw_fall_unused[i])
        );
    end

    logic [PWM_W-1:0]            pwm_cnt;
    logic [N_LED-1:0][PWM_W-1:0] shadow;

    // Duties are captured only on the last count so each period is uniform.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_cnt <= '0;
            shadow  <= '0;
            led_o   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (pwm_cnt == CNT_TOP) begin
                shadow <= led_duty_i;
            end
            for (int i = 0; i < N_LED; i++) begin
                led_o[i] <= (pwm_cnt < shadow[i]);
            end
        end
    end

`ifdef BOARD_IO_EVENT_IRQ_EN
    logic [N_BTN-1:0] evt;
    logic             irq;

    // A new rise overrides a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt <= '0;
            irq <= 1'b0;
        end else begin
            evt <= (evt & ~evt_clr_i) | btn_rise_o;
            irq <= |evt;
        end
    end

    assign evt_o = evt;
    assign irq_o = irq;
`else
    logic [N_BTN-1:0] evt_clr_unused;

    assign evt_clr_unused = evt_clr_i;
    assign evt_o          = '0;
    assign irq_o          = 1'b0;
`endif

endmodule

`default_nettype wire
